scan_tile_responder: RTL
========================

# scan_tile_responder

Single-clock, oversampled responder for one tile of the scan chain. It receives the scan clock, data, select and latch-enable signals that the scan controller drives down the chain. It shifts stimulus in, applies the latched byte to its user design, and captures the design's outputs for shift-back. It regenerates every chain signal for the next tile, so tiles chain exactly as the existing scan elements do, but all state is timed by the system clock instead of the scan clock.

## Interface
Parameters:
- NUM_IOS, 8, width of the design input and output buses and length of the shift register.
- SYNC_STAGES, 2, synchronizer depth on each incoming chain signal (minimum 2).

Ports:
- clk  input  1  system clock (wb_clk_i domain); all flops sample on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_in  input  1  scan clock from the previous tile.
- data_in  input  1  serial scan data from the previous tile.
- scan_select_in  input  1  1 = next scan-clock rise captures design outputs; 0 = shift.
- latch_enable_in  input  1  rising edge transfers the shift register to the design inputs.
- clk_out  output  1  regenerated scan clock to the next tile.
- data_out  output  1  serial data to the next tile.
- scan_select_out  output  1  regenerated select to the next tile.
- latch_enable_out  output  1  regenerated latch enable to the next tile.
- module_data_in  output  NUM_IOS  latched stimulus to the user design.
- module_data_out  input  NUM_IOS  user design outputs.
- frame_error  output  1  sticky flag: latch with wrong shift count.

## Operation
- Each of the four chain inputs passes through a SYNC_STAGES flop synchronizer. One further register stage keeps the previous synchronized value for edge detection.
- clk_out, scan_select_out and latch_enable_out are the synchronized values, registered once more (the edge-detect stage).
- Scan-clock rise with sync select = 1: sr <= module_data_out (parallel capture); bit_cnt <= 0.
- Scan-clock rise with sync select = 0: sr <= {sr[NUM_IOS-2:0], sync data_in}; bit_cnt increments and saturates at its maximum.
- Scan-clock fall: data_out <= sr[NUM_IOS-1]. The output updates half a scan period after the shift, which gives hold margin at the next tile.
- Latch-enable rise: module_data_in <= sr.
  - frame_error is set if bit_cnt != NUM_IOS.
  - bit_cnt is not cleared by the latch; only a capture clears it.
- Simultaneous latch-enable rise and scan-clock rise in the same clk cycle: the latch takes the pre-update sr. The shift or capture still happens.
- frame_error clears only on reset.
- bit_cnt width is $clog2(NUM_IOS+1)+1, so over-shifting is distinguishable from an exact count.

## Timing
- Reset values:
  - sr, module_data_in, bit_cnt: 0.
  - data_out, clk_out, scan_select_out, latch_enable_out, frame_error: 0.
  - All synchronizer flops: 0.
- Input-to-forwarded-output latency is SYNC_STAGES+1 clk cycles. The default is 3.
- A scan-clock rise on clk_in updates sr SYNC_STAGES+1 cycles later.
- module_data_in updates SYNC_STAGES+1 cycles after the latch_enable_in rise.
- data_out changes SYNC_STAGES+1 cycles after the clk_in fall.
- Constraints on the driver (violations are not detected):
  - clk_in high and low phases: each ≥ SYNC_STAGES+2 clk cycles.
  - data_in and scan_select_in must be stable from 1 clk before the clk_in rise until SYNC_STAGES+2 cycles after it.
- Reset mid-frame aborts the frame. Chain outputs drop to 0 in the reset cycle, and the first edge seen after reset is taken from the synchronized level.

## Structure
- Shared package scan_pkg: default NUM_IOS, default SYNC_STAGES, and a function for the bit_cnt width.
- One sub-module, scan_sync_edge: an N-stage synchronizer plus a previous-value register. Outputs: level, rise, fall. It is instantiated four times.
- The top level holds sr, bit_cnt, data_out, module_data_in and frame_error.

## Test plan
All cases use NUM_IOS=8, SYNC_STAGES=2, and 4 clk cycles per scan phase.
- Shift 0xA5, MSB first, with select=0, then pulse latch_enable_in → module_data_in = 0xA5 at cycle 3 after the latch rise; frame_error = 0.
- Drive module_data_out = 0x3C, one scan clock with select=1, then 8 shift clocks → data_out sequence 0,0,1,1,1,1,0,0 at the successive scan falls.
- Chain two instances, shift 16 bits 0x12 then 0x34 → the first tile latches 0x34 and the second latches 0x12.
- Shift 7 bits then latch → frame_error = 1. A further capture plus 8 shifts plus latch leaves it at 1 until reset.
- Latch-enable rise in the same cycle as the 8th shift rise → module_data_in holds the 7-shift value.
- Assert reset after 4 shifts → all outputs are 0 next cycle. Then a full 8-bit frame of 0xFF → 0xFF latched, no frame_error.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared defaults and sizing helpers for the scan-chain tile responder.
package scan_pkg;

    localparam int DEFAULT_NUM_IOS     = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // One extra bit beyond what NUM_IOS needs, so an over-shifted frame never aliases to an exact count.
    function automatic int cnt_width(input int num_ios);
        return $clog2(num_ios + 1) + 1;
    endfunction

endpackage

// File: rtl/scan_sync_edge.sv
// N-stage synchronizer for one chain signal, plus a previous-value stage for edge detection.
module scan_sync_edge #(
    parameter int STAGES = scan_pkg::DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic prev,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign prev  = prev_q;
    assign rise  =  level & ~prev_q;
    assign fall  = ~level &  prev_q;

endmodule

// File: rtl/scan_tile_responder.sv
// Oversampled scan-chain tile: shifts, captures and latches on system-clock-detected scan edges.
module scan_tile_responder
    import scan_pkg::*;
#(
    parameter int NUM_IOS     = DEFAULT_NUM_IOS,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_in,
    input  logic               data_in,
    input  logic               scan_select_in,
    input  logic               latch_enable_in,
    output logic               clk_out,
    output logic               data_out,
    output logic               scan_select_out,
    output logic               latch_enable_out,
    output logic [NUM_IOS-1:0] module_data_in,
    input  logic [NUM_IOS-1:0] module_data_out,
    output logic               frame_error
);

    localparam int CNT_W = cnt_width(NUM_IOS);

    logic sclk_level, sclk_prev, sclk_rise, sclk_fall;
    logic data_level, data_prev, data_rise, data_fall;
    logic sel_level,  sel_prev,  sel_rise,  sel_fall;
    logic le_level,   le_prev,   le_rise,   le_fall;

    scan_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .reset(reset), .d(clk_in),
        .level(sclk_level), .prev(sclk_prev), .rise(sclk_rise), .fall(sclk_fall)
    );

    scan_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .reset(reset), .d(data_in),
        .level(data_level), .prev(data_prev), .rise(data_rise), .fall(data_fall)
    );

    scan_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sel (
        .clk(clk), .reset(reset), .d(scan_select_in),
        .level(sel_level), .prev(sel_prev), .rise(sel_rise), .fall(sel_fall)
    );

    scan_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_le (
        .clk(clk), .reset(reset), .d(latch_enable_in),
        .level(le_level), .prev(le_prev), .rise(le_rise), .fall(le_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_level, data_prev, data_rise, data_fall,
                           sel_rise, sel_fall, le_level, le_fall};

    logic [NUM_IOS-1:0] sr_q, sr_d;
    logic [NUM_IOS-1:0] module_data_in_q, module_data_in_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               data_out_q, data_out_d;
    logic               frame_error_q, frame_error_d;

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sr_d             = sr_q;
        bit_cnt_d        = bit_cnt_q;
        data_out_d       = data_out_q;
        module_data_in_d = module_data_in_q;
        frame_error_d    = frame_error_q;

        if (sclk_rise) begin
            if (sel_level) begin
                sr_d      = module_data_out;
                bit_cnt_d = '0;
            end else begin
                sr_d = {sr_q[NUM_IOS-2:0], data_level};
                if (bit_cnt_q != '1) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end

        if (sclk_fall) begin
            data_out_d = sr_q[NUM_IOS-1];
        end

        // Reads sr_q/bit_cnt_q, so a coincident shift edge is latched from its pre-update state.
        if (le_rise) begin
            module_data_in_d = sr_q;
            if (bit_cnt_q != CNT_W'(NUM_IOS)) begin
                frame_error_d = 1'b1;
            end
        end
    end

    // NOTE: the shift register is a handful of flops, not a memory, so it is reset with everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q             <= '0;
            bit_cnt_q        <= '0;
            data_out_q       <= 1'b0;
            module_data_in_q <= '0;
            frame_error_q    <= 1'b0;
        end else begin
            sr_q             <= sr_d;
            bit_cnt_q        <= bit_cnt_d;
            data_out_q       <= data_out_d;
            module_data_in_q <= module_data_in_d;
            frame_error_q    <= frame_error_d;
        end
    end

    assign clk_out          = sclk_prev;
    assign scan_select_out  = sel_prev;
    assign latch_enable_out = le_prev;
    assign data_out         = data_out_q;
    assign module_data_in   = module_data_in_q;
    assign frame_error      = frame_error_q;

endmodule
